// File: rtl/hazard_control.sv
// rtl/hazard_control.sv - pipeline stall/flush controller with saturating stall and flush statistics
module hazard_control #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             mem_read_ex,
  input  logic [4:0]       rd_ex,
  input  logic             branch_taken_ex,
  input  logic             mc_start_ex,
  input  logic             mc_done,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mc_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              uses_rs1;
  logic              uses_rs2;
  logic              load_use;
  logic              wait_last;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode_id)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                    ((uses_rs1 && (rd_ex == rs1_id)) || (uses_rs2 && (rd_ex == rs2_id)));
  assign wait_last = (wait_cnt == WAIT_LAST);

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if (state == RUN) begin
      if (branch_taken_ex) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (mc_start_ex) begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_bubble = 1'b1;
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end else if (!mc_done) begin
      // Freeze everything up to EX; EX/MEM gets bubbles until the result is valid.
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mc_error     <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!branch_taken_ex && mc_start_ex) begin
            state    <= MC_WAIT;
            wait_cnt <= '0;
          end
        end
        MC_WAIT: begin
          if (mc_done) begin
            state <= RUN;
          end else if (wait_last) begin
            state    <= RUN;
            mc_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= RUN;
      endcase

      if (cnt_clr) begin
        stall_cycles <= '0;
        flush_count  <= '0;
      end else begin
        if (!pc_write && (stall_cycles != CNT_MAX))
          stall_cycles <= stall_cycles + CNT_W'(1);
        if (if_id_flush && (flush_count != CNT_MAX))
          flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// tb/tb_hazard_control.sv - directed self-checking bench for hazard_control
module tb_hazard_control;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       opcode_id;
  logic [4:0]       rs1_id, rs2_id, rd_ex;
  logic             mem_read_ex, branch_taken_ex, mc_start_ex, mc_done, cnt_clr;
  logic             pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, ex_mem_bubble;
  logic             mc_error;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [5:0]       ctrl;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] C_DEF  = 6'b111000;
  localparam logic [5:0] C_LU   = 6'b001010;
  localparam logic [5:0] C_BR   = 6'b111110;
  localparam logic [5:0] C_MC   = 6'b000001;

  hazard_control #(.MC_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .mem_read_ex(mem_read_ex), .rd_ex(rd_ex), .branch_taken_ex(branch_taken_ex),
    .mc_start_ex(mc_start_ex), .mc_done(mc_done), .cnt_clr(cnt_clr),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .mc_error(mc_error), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, ex_mem_bubble};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    opcode_id = 7'b0110011; rs1_id = 5'd1; rs2_id = 5'd2; rd_ex = 5'd0;
    mem_read_ex = 1'b0; branch_taken_ex = 1'b0; mc_start_ex = 1'b0;
    mc_done = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic drive_lu(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd);
    opcode_id = op; rs1_id = r1; rs2_id = r2; rd_ex = rd; mem_read_ex = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    check("reset_ctrl", ctrl, C_DEF);
    check("reset_stall", stall_cycles, 0);
    check("reset_flush", flush_count, 0);
    check("reset_err", mc_error, 0);
    tick();
    rst_n = 1'b1;
    tick();

    drive_lu(7'b0110011, 5'd1, 5'd5, 5'd5);
    #1 check("lu_rs2_ctrl", ctrl, C_LU);
    tick();
    idle();
    #1 check("lu_rs2_cleared", ctrl, C_DEF);
    check("lu_rs2_stall", stall_cycles, 1);

    drive_lu(7'b0110011, 5'd0, 5'd0, 5'd0);
    #1 check("lu_rd0", ctrl, C_DEF);
    drive_lu(7'b0110111, 5'd5, 5'd5, 5'd5);
    #1 check("lu_lui", ctrl, C_DEF);
    drive_lu(7'b0010011, 5'd3, 5'd7, 5'd7);
    #1 check("itype_rs2", ctrl, C_DEF);
    drive_lu(7'b0000011, 5'd9, 5'd4, 5'd9);
    #1 check("load_rs1", ctrl, C_LU);
    idle();
    tick();
    check("no_stall_count", stall_cycles, 1);

    drive_lu(7'b0110011, 5'd5, 5'd5, 5'd5);
    branch_taken_ex = 1'b1;
    #1 check("branch_ctrl", ctrl, C_BR);
    tick();
    idle();
    check("branch_flush", flush_count, 1);
    check("branch_stall", stall_cycles, 1);

    mc_start_ex = 1'b1;
    #1 check("mc_start_ctrl", ctrl, C_MC);
    tick();
    mc_start_ex = 1'b0;
    for (int i = 1; i < 4; i++) begin
      branch_taken_ex = (i == 2);
      #1 check($sformatf("mc_wait%0d", i), ctrl, C_MC);
      tick();
    end
    branch_taken_ex = 1'b0;
    check("mc_branch_ignored", flush_count, 1);
    mc_done = 1'b1;
    #1 check("mc_done_ctrl", ctrl, C_DEF);
    tick();
    #1 check("mc_done_in_run", ctrl, C_DEF);
    mc_done = 1'b0;
    check("mc_stall_count", stall_cycles, 5);

    mc_start_ex = 1'b1;
    tick();
    mc_start_ex = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1 check($sformatf("to_wait%0d", i), ctrl, C_MC);
      if (i == 7) check("to_err_before", mc_error, 0);
      tick();
    end
    check("to_err", mc_error, 1);
    #1 check("to_back_run", ctrl, C_DEF);
    check("to_stall", stall_cycles, 14);

    drive_lu(7'b0110011, 5'd5, 5'd5, 5'd5);
    tick();
    check("sat_15", stall_cycles, 15);
    tick();
    check("sat_hold", stall_cycles, 15);

    cnt_clr = 1'b1;
    tick();
    idle();
    check("clr_stall", stall_cycles, 0);
    check("clr_flush", flush_count, 0);
    check("clr_err_kept", mc_error, 1);

    mc_start_ex = 1'b1;
    tick();
    mc_start_ex = 1'b0;
    tick();
    #1 check("rst_wait_ctrl", ctrl, C_MC);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_ctrl", ctrl, C_DEF);
    check("rst_mid_stall", stall_cycles, 0);
    check("rst_mid_err", mc_error, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_after_run", ctrl, C_DEF);
    check("rst_after_flush", flush_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
